shift_left_two: RTL and testbench

- Registered shift-left-by-two stage for the 32-bit datapath.
- Converts a sign-extended word offset into a byte offset for branch-target computation in the ID/EX path.
- Wrapped in a valid/ready pipeline stage with a 2-entry skid buffer so it can sit between stalling pipeline stages without combinational ready paths.
- One clock; reset is asynchronous and active-low.

---
 rtl/shift_left_two.sv | 118 +++++++++++
 tb/tb_shift_left_two.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_two.sv
// rtl/shift_left_two.sv - registered shift-left-by-SHIFT stage with 2-entry skid buffer.
// Define SHIFT_LEFT_TWO_LOST_BITS_EN to enable lost_bits detection; otherwise lost_bits is tied to 0.
module shift_left_two #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lost_bits
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, out_free;
  logic             load_out_in, load_out_skid, load_skid;
  logic [WIDTH-1:0] shifted;

  // Logical shift: upper SHIFT bits fall off, low SHIFT bits fill with zero.
  assign shifted = data_in << SHIFT;

  always_comb begin
    accept        = in_valid && in_ready_q;
    out_free      = !out_valid_q || out_ready;
    load_out_in   = accept && out_free;
    load_skid     = accept && !out_free;
    // in_ready is low whenever the skid holds a word, so this never coincides with accept.
    load_out_skid = skid_valid_q && out_ready;

    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (load_out_skid) begin
      skid_valid_d = 1'b0;
    end else if (load_out_in) begin
      out_valid_d = 1'b1;
    end else if (load_skid) begin
      skid_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;

    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    if (load_out_skid) begin
      out_data_d = skid_data_q;
    end else if (load_out_in) begin
      out_data_d = shifted;
    end
    if (load_skid) begin
      skid_data_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef SHIFT_LEFT_TWO_LOST_BITS_EN
  logic lost_in;
  logic out_lost_q, out_lost_d;
  logic skid_lost_q, skid_lost_d;

  assign lost_in = |data_in[WIDTH-1 -: SHIFT];

  always_comb begin
    out_lost_d  = out_lost_q;
    skid_lost_d = skid_lost_q;
    if (load_out_skid) begin
      out_lost_d = skid_lost_q;
    end else if (load_out_in) begin
      out_lost_d = lost_in;
    end
    if (load_skid) begin
      skid_lost_d = lost_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lost_q  <= 1'b0;
      skid_lost_q <= 1'b0;
    end else begin
      out_lost_q  <= out_lost_d;
      skid_lost_q <= skid_lost_d;
    end
  end

  assign lost_bits = out_lost_q;
`else
  assign lost_bits = 1'b0;
`endif

  assign data_out  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_shift_left_two.sv
// tb/tb_shift_left_two.sv - self-checking bench for shift_left_two.
// Inputs change and outputs are sampled on the falling edge; transfers happen on the rising edge.
module tb_shift_left_two;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        lost_bits;

  int errors = 0;
  int checks = 0;

  shift_left_two #(.WIDTH(32), .SHIFT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lost_bits (lost_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [31:0] x);
    return x * 32'd4;
  endfunction

  function automatic logic ref_lost(input logic [31:0] x);
`ifdef SHIFT_LEFT_TWO_LOST_BITS_EN
    return x >= 32'h4000_0000;
`else
    return (x != x);
`endif
  endfunction

  logic [31:0] words [3];
  logic [31:0] q [$];
  logic [31:0] front, held_data;
  logic        held_lost, stalled;
  int          accepted, cycles;

  initial begin
    words[0] = 32'h0000_0000;
    words[1] = 32'hFFFF_FFFF;
    words[2] = 32'hAAAA_AAAA;
    rst_n     = 1'b0;
    data_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_lost", {31'b0, lost_bits}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_after_edge", {31'b0, in_ready}, 32'h1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stream_valid", {31'b0, out_valid}, 32'h1);
        chk("stream_data", data_out, ref_data(words[i-1]));
        chk("stream_lost", {31'b0, lost_bits}, {31'b0, ref_lost(words[i-1])});
      end
      in_valid = 1'b1;
      data_in  = words[i];
    end
    @(negedge clk);
    chk("stream_valid", {31'b0, out_valid}, 32'h1);
    chk("stream_data", data_out, 32'hAAAA_AAA8);
    chk("stream_lost", {31'b0, lost_bits}, {31'b0, ref_lost(words[2])});
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", {31'b0, out_valid}, 32'h0);

    // Backpressure fills the skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h0000_0001;
    @(negedge clk);
    chk("bp_data_first", data_out, 32'h0000_0004);
    chk("bp_in_ready_one", {31'b0, in_ready}, 32'h1);
    data_in = 32'h4000_0000;
    @(negedge clk);
    chk("bp_in_ready_full", {31'b0, in_ready}, 32'h0);
    chk("bp_hold", data_out, 32'h0000_0004);
    data_in = 32'h1234_5678;
    @(negedge clk);
    chk("bp_hold2", data_out, 32'h0000_0004);
    chk("bp_in_ready_still0", {31'b0, in_ready}, 32'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_second_data", data_out, 32'h0000_0000);
    chk("bp_second_lost", {31'b0, lost_bits}, {31'b0, ref_lost(32'h4000_0000)});
    chk("bp_in_ready_back", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    chk("bp_no_third", {31'b0, out_valid}, 32'h0);

    // Random traffic against a queue model
    accepted = 0;
    cycles   = 0;
    stalled  = 1'b0;
    held_data = '0;
    held_lost = 1'b0;
    while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      if (stalled) begin
        chk("rnd_stable_data", data_out, held_data);
        chk("rnd_stable_lost", {31'b0, lost_bits}, {31'b0, held_lost});
      end
      in_valid  = (accepted < 1000) && ($urandom_range(3, 0) != 0);
      data_in   = $urandom;
      out_ready = $urandom_range(1, 0) == 1;
      if (out_valid && out_ready) begin
        front = q.pop_front();
        chk("rnd_data", data_out, ref_data(front));
        chk("rnd_lost", {31'b0, lost_bits}, {31'b0, ref_lost(front)});
      end
      if (in_valid && in_ready) begin
        q.push_back(data_in);
        accepted++;
      end
      stalled   = out_valid && !out_ready;
      held_data = data_out;
      held_lost = lost_bits;
    end
    chk("rnd_completed", {31'b0, cycles < 20000}, 32'h1);
    chk("rnd_accepted", accepted, 32'd1000);
    in_valid = 1'b0;

    // Asynchronous reset with the skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h0000_0123;
    @(negedge clk);
    data_in = 32'h0000_0456;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_skid_full", {31'b0, in_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_data_out", data_out, 32'h0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'h0);
    chk("ar_lost", {31'b0, lost_bits}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_stale", {31'b0, out_valid}, 32'h0);
    end
    chk("ar_in_ready_back", {31'b0, in_ready}, 32'h1);

    // Top bits set, result zero
    in_valid = 1'b1;
    data_in  = 32'hC000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("top_valid", {31'b0, out_valid}, 32'h1);
    chk("top_data", data_out, 32'h0);
    chk("top_lost", {31'b0, lost_bits}, {31'b0, ref_lost(32'hC000_0000)});
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
